product_accumulator: RTL and testbench

- Registered downstream stage for the 4x4 array multiplier.
- Consumes one 8-bit product per valid/ready handshake and sums N_TERMS consecutive products into an accumulator.
- Presents the completed sum on an output valid/ready interface, so multiplier results become dot-product / MAC frames for the next consumer.

---
 rtl/product_accumulator_if.sv | 25 ++
 rtl/product_accumulator.sv | 90 +++++++++
 tb/tb_product_accumulator.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the 4x4 multiplier, the product accumulator and its consumer.
// master = product source / result sink side, slave = accumulator side.
interface product_accumulator_if #(
    parameter int PW    = 8,
    parameter int ACC_W = 16
);
    logic [PW-1:0]    p_in;
    logic             p_valid;
    logic             p_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             busy;
    logic             overflow;

    modport master (
        output p_in, p_valid, acc_ready,
        input  p_ready, acc_out, acc_valid, busy, overflow
    );

    modport slave (
        input  p_in, p_valid, acc_ready,
        output p_ready, acc_out, acc_valid, busy, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned products per frame and hands the total downstream over valid/ready.
// Optional build macro ACC_SATURATE_EN clamps the sum at all-ones instead of wrapping.
module product_accumulator #(
    parameter int PW      = 8,
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    product_accumulator_if.slave  bus
);
    localparam int            CW   = 8;
    localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_next;

    assign accept = bus.p_valid && (state_q == ACCUM);
    // One extra bit keeps the carry so overflow is visible in both builds.
    assign sum    = {1'b0, acc_q} + (ACC_W+1)'(bus.p_in);

`ifdef ACC_SATURATE_EN
    assign acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_next;
                    ovf_d = ovf_q | sum[ACC_W];
                    if (count_q == LAST) begin
                        acc_out_d = acc_next;
                        count_d   = '0;
                        state_d   = HOLD;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                // Nothing is accepted in the handshake cycle; next frame starts a cycle later.
                if (bus.acc_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            acc_out_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.p_ready   = (state_q == ACCUM);
    assign bus.acc_valid = (state_q == HOLD);
    assign bus.acc_out   = acc_out_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (count_q != '0) || (state_q == HOLD);
endmodule

// File: tb/tb_product_accumulator.sv
// Directed + randomized checks of product_accumulator in three configurations against a frame-sum model.
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // index 0: defaults, 1: ACC_W=8, 2: N_TERMS=1
    logic [7:0]  pin [3];
    logic        pv  [3];
    logic        ar  [3];
    logic [15:0] aout[3];
    logic        prdy[3];
    logic        aval[3];
    logic        bsy [3];
    logic        ovf [3];

    product_accumulator_if #(.PW(8), .ACC_W(16)) if0 ();
    product_accumulator_if #(.PW(8), .ACC_W(8))  if8 ();
    product_accumulator_if #(.PW(8), .ACC_W(16)) if1 ();

    product_accumulator #(.PW(8), .ACC_W(16), .N_TERMS(4)) d0 (.clk(clk), .rst(rst), .bus(if0));
    product_accumulator #(.PW(8), .ACC_W(8),  .N_TERMS(4)) d8 (.clk(clk), .rst(rst), .bus(if8));
    product_accumulator #(.PW(8), .ACC_W(16), .N_TERMS(1)) d1 (.clk(clk), .rst(rst), .bus(if1));

    assign if0.p_in = pin[0]; assign if0.p_valid = pv[0]; assign if0.acc_ready = ar[0];
    assign if8.p_in = pin[1]; assign if8.p_valid = pv[1]; assign if8.acc_ready = ar[1];
    assign if1.p_in = pin[2]; assign if1.p_valid = pv[2]; assign if1.acc_ready = ar[2];

    assign aout[0] = if0.acc_out;           assign aout[1] = {8'h00, if8.acc_out}; assign aout[2] = if1.acc_out;
    assign prdy[0] = if0.p_ready;           assign prdy[1] = if8.p_ready;          assign prdy[2] = if1.p_ready;
    assign aval[0] = if0.acc_valid;         assign aval[1] = if8.acc_valid;        assign aval[2] = if1.acc_valid;
    assign bsy[0]  = if0.busy;              assign bsy[1]  = if8.busy;             assign bsy[2]  = if1.busy;
    assign ovf[0]  = if0.overflow;          assign ovf[1]  = if8.overflow;         assign ovf[2]  = if1.overflow;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame result from the true (unbounded) sum of the frame's products.
    function automatic longint model_sum(input longint exact, input int accw);
        longint mx = (longint'(1) << accw) - 1;
`ifdef ACC_SATURATE_EN
        return (exact > mx) ? mx : exact;
`else
        return exact & mx;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; optional idle cycle before each product and optional HOLD stall.
    task automatic run_frame(input int k, input int n, input int accw, input int p[8],
                             input bit gap, input int stall);
        longint exact = 0;
        longint mx    = (longint'(1) << accw) - 1;
        longint exp_sum;
        ar[k] = (stall == 0);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                pv[k]  = 1'b0;
                pin[k] = 8'($urandom);
                step();
                chk($sformatf("gap_busy[%0d]", k), bsy[k], (i != 0));
            end
            pv[k]  = 1'b1;
            pin[k] = 8'(p[i]);
            chk($sformatf("acc_ready_in[%0d]", k), prdy[k], 1);
            chk($sformatf("acc_nvalid[%0d]", k), aval[k], 0);
            chk($sformatf("busy_pre[%0d]", k), bsy[k], (i != 0));
            step();
            exact += p[i];
        end
        // Junk offered while holding must not leak into the next frame.
        pv[k]  = 1'b1;
        pin[k] = 8'($urandom);
        exp_sum = model_sum(exact, accw);
        chk($sformatf("hold_valid[%0d]", k), aval[k], 1);
        chk($sformatf("hold_pready[%0d]", k), prdy[k], 0);
        chk($sformatf("hold_busy[%0d]", k), bsy[k], 1);
        chk($sformatf("acc_out[%0d]", k), aout[k], exp_sum);
        chk($sformatf("overflow[%0d]", k), ovf[k], (exact > mx));
        for (int s = 0; s < stall; s++) begin
            step();
            chk($sformatf("stall_valid[%0d]", k), aval[k], 1);
            chk($sformatf("stall_pready[%0d]", k), prdy[k], 0);
            chk($sformatf("stall_out[%0d]", k), aout[k], exp_sum);
        end
        ar[k] = 1'b1;
        step();
        chk($sformatf("post_valid[%0d]", k), aval[k], 0);
        chk($sformatf("post_pready[%0d]", k), prdy[k], 1);
        chk($sformatf("post_busy[%0d]", k), bsy[k], 0);
        chk($sformatf("post_ovf[%0d]", k), ovf[k], 0);
        pv[k] = 1'b0;
    endtask

    initial begin
        int p[8];
        for (int k = 0; k < 3; k++) begin
            pin[k] = '0; pv[k] = 1'b0; ar[k] = 1'b0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("rst_pready", prdy[k], 1);
            chk("rst_valid", aval[k], 0);
            chk("rst_busy", bsy[k], 0);
            chk("rst_ovf", ovf[k], 0);
            chk("rst_out", aout[k], 0);
        end
        step();
        rst = 1'b0;
        step();

        // Basic frame, continuous ready, then 5-cycle stall
        run_frame(0, 4, 16, '{120, 81, 110, 0, 0, 0, 0, 0}, 1'b0, 0);
        run_frame(0, 4, 16, '{120, 81, 110, 0, 0, 0, 0, 0}, 1'b0, 5);

        // Narrow accumulator overflow, then clean frame
        run_frame(1, 4, 8, '{120, 81, 110, 0, 0, 0, 0, 0}, 1'b0, 0);
        run_frame(1, 4, 8, '{1, 1, 1, 1, 0, 0, 0, 0}, 1'b0, 0);

        // Gapped valid
        run_frame(0, 4, 16, '{225, 225, 225, 225, 0, 0, 0, 0}, 1'b1, 0);

        // Asynchronous reset mid-frame after two accepts
        pv[0] = 1'b1; pin[0] = 8'd120;
        step();
        step();
        pv[0] = 1'b0;
        chk("mid_busy", bsy[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bsy[0], 0);
        chk("arst_pready", prdy[0], 1);
        chk("arst_valid", aval[0], 0);
        chk("arst_out", aout[0], 0);
        step();
        rst = 1'b0;
        step();
        run_frame(0, 4, 16, '{1, 2, 3, 4, 0, 0, 0, 0}, 1'b0, 0);

        // Single-term frames
        run_frame(2, 1, 16, '{72, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 0);
        run_frame(2, 1, 16, '{99, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 0);

        // Randomized frames on all three configurations
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < 8; i++) p[i] = int'($urandom_range(0, 255));
            run_frame(0, 4, 16, p, 1'($urandom), int'($urandom_range(0, 3)));
            for (int i = 0; i < 8; i++) p[i] = int'($urandom_range(0, 255));
            run_frame(1, 4, 8, p, 1'($urandom), int'($urandom_range(0, 3)));
            for (int i = 0; i < 8; i++) p[i] = int'($urandom_range(0, 255));
            run_frame(2, 1, 16, p, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
